// File: rtl/tile_pkg.sv
// Shared types for the piano-lane tile controller: coordinate width and per-slot state.
package tile_pkg;

    localparam int unsigned COORD_W  = 10;
    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SCREEN_H = 480;

    typedef logic [COORD_W-1:0] coord_t;

    typedef struct packed {
        logic   valid;
        coord_t y;
        coord_t step;
    } tile_slot_t;

endpackage

// File: rtl/tile_slot.sv
// One falling-tile slot: holds valid/y/step, moves by its latched step each frame,
// and reports when its lower edge has reached the bottom row.
module tile_slot
    import tile_pkg::COORD_W, tile_pkg::coord_t, tile_pkg::tile_slot_t;
#(
    parameter int unsigned TILE_H   = 75,
    parameter int unsigned SCREEN_H = 480
) (
    input  logic   frame_clk,
    input  logic   Reset,
    input  logic   spawn,
    input  logic   clear,
    input  coord_t step_in,
    output logic   valid,
    output coord_t y,
    output logic   at_bottom
);

    localparam int unsigned SUM_W = COORD_W + 1;

    tile_slot_t       slot_q;
    tile_slot_t       slot_d;
    logic [SUM_W-1:0] y_bot;
    logic [SUM_W-1:0] y_next;

    always_comb begin
        y_bot  = SUM_W'(slot_q.y) + SUM_W'(TILE_H);
        y_next = SUM_W'(slot_q.y) + SUM_W'(slot_q.step);
    end

    // Clear beats spawn beats move; a cleared slot reads back y=0.
    always_comb begin
        slot_d = slot_q;
        if (clear) begin
            slot_d.valid = 1'b0;
            slot_d.y     = '0;
        end else if (spawn) begin
            slot_d.valid = 1'b1;
            slot_d.y     = '0;
            slot_d.step  = step_in;
        end else if (slot_q.valid) begin
            // Clamp only guards an unreachable overflow; tiles retire well before it.
            slot_d.y = y_next[COORD_W] ? '1 : y_next[COORD_W-1:0];
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            slot_q <= '0;
        end else begin
            slot_q <= slot_d;
        end
    end

    assign valid     = slot_q.valid;
    assign y         = slot_q.y;
    assign at_bottom = slot_q.valid && (y_bot >= SUM_W'(SCREEN_H - 1));

endmodule

// File: rtl/tile_lane_ctrl.sv
// Piano-lane controller: SLOTS falling tiles, hit-window resolution, fall-off misses, spawn.
// Optional macro TILE_LANE_AUTOPLAY_EN: ignore hit and auto-retire every tile in the window.
module tile_lane_ctrl
    import tile_pkg::COORD_W, tile_pkg::coord_t;
#(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned LANE_X    = 400,
    parameter int unsigned TILE_H    = 75,
    parameter int unsigned SCREEN_H  = 480,
    parameter int unsigned HIT_TOP   = 360,
    parameter int unsigned BASE_STEP = 3
) (
    input  logic                     Reset,
    input  logic                     frame_clk,
    input  logic                     newNote,
    input  logic                     hit,
    input  logic [3:0]               speed,
    output logic [COORD_W-1:0]       tile_x,
    output logic [COORD_W-1:0]       tile_s,
    output logic [COORD_W*SLOTS-1:0] tile_y,
    output logic [SLOTS-1:0]         tile_v,
    output logic                     hit_ok,
    output logic                     miss,
    output logic                     spawn_drop
);

    localparam int unsigned SUM_W = COORD_W + 1;

    coord_t           slot_y [SLOTS];
    logic [SLOTS-1:0] slot_v;
    logic [SLOTS-1:0] slot_bot;
    logic [SLOTS-1:0] slot_hittable;
    logic [SLOTS-1:0] slot_spawn;
    logic [SLOTS-1:0] slot_clr;
    logic [SLOTS-1:0] free_sel;
    logic             free_found;
    coord_t           step_in;

    logic hit_ok_q, hit_ok_d;
    logic miss_q, miss_d;
    logic spawn_drop_q, spawn_drop_d;

    assign step_in = COORD_W'(BASE_STEP) + COORD_W'(speed);

    for (genvar i = 0; i < SLOTS; i++) begin : g_slot
        tile_slot #(
            .TILE_H   (TILE_H),
            .SCREEN_H (SCREEN_H)
        ) u_slot (
            .frame_clk (frame_clk),
            .Reset     (Reset),
            .spawn     (slot_spawn[i]),
            .clear     (slot_clr[i]),
            .step_in   (step_in),
            .valid     (slot_v[i]),
            .y         (slot_y[i]),
            .at_bottom (slot_bot[i])
        );
        assign tile_y[COORD_W*i +: COORD_W] = slot_y[i];
        assign slot_hittable[i] = slot_v[i] &&
            ((SUM_W'(slot_y[i]) + SUM_W'(TILE_H)) >= SUM_W'(HIT_TOP));
    end

`ifdef TILE_LANE_AUTOPLAY_EN
    logic unused_hit;
    assign unused_hit = hit;
`else
    logic [SLOTS-1:0] tgt_sel;
    logic             tgt_found;
    coord_t           tgt_y;

    // Target is the lowest-on-screen tile; strict compare keeps ties on the lowest index.
    always_comb begin
        tgt_sel   = '0;
        tgt_found = 1'b0;
        tgt_y     = '0;
        for (int i = 0; i < SLOTS; i++) begin
            if (slot_v[i] && (!tgt_found || (slot_y[i] > tgt_y))) begin
                tgt_found  = 1'b1;
                tgt_y      = slot_y[i];
                tgt_sel    = '0;
                tgt_sel[i] = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        free_sel   = '0;
        free_found = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            if (!slot_v[i] && !free_found) begin
                free_found  = 1'b1;
                free_sel[i] = 1'b1;
            end
        end
    end

    // Resolve hit, then fall-off on the remaining tiles, then spawn into a pre-edge free slot.
    always_comb begin
        slot_clr     = '0;
        slot_spawn   = '0;
        hit_ok_d     = 1'b0;
        miss_d       = 1'b0;
        spawn_drop_d = 1'b0;
`ifdef TILE_LANE_AUTOPLAY_EN
        slot_clr = slot_hittable;
        hit_ok_d = |slot_hittable;
`else
        if (hit) begin
            if (|(tgt_sel & slot_hittable)) begin
                slot_clr = tgt_sel;
                hit_ok_d = 1'b1;
            end else begin
                miss_d = 1'b1;
            end
        end
`endif
        if (|(slot_bot & ~slot_clr)) begin
            miss_d   = 1'b1;
            slot_clr = slot_clr | slot_bot;
        end
        if (newNote) begin
            if (free_found) begin
                slot_spawn = free_sel;
            end else begin
                spawn_drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
        if (Reset) begin
            hit_ok_q     <= 1'b0;
            miss_q       <= 1'b0;
            spawn_drop_q <= 1'b0;
        end else begin
            hit_ok_q     <= hit_ok_d;
            miss_q       <= miss_d;
            spawn_drop_q <= spawn_drop_d;
        end
    end

    assign tile_x     = COORD_W'(LANE_X);
    assign tile_s     = COORD_W'(TILE_H);
    assign tile_v     = slot_v;
    assign hit_ok     = hit_ok_q;
    assign miss       = miss_q;
    assign spawn_drop = spawn_drop_q;

endmodule

// File: tb/tb_tile_lane_ctrl.sv
// Bench for tile_lane_ctrl: directed scenarios plus random traffic against a frame-level model.
module tb_tile_lane_ctrl;

    localparam int SLOTS   = 4;
    localparam int TILE_H  = 75;
    localparam int SCR_H   = 480;
    localparam int HIT_TOP = 360;
    localparam int BASE    = 3;

    logic              Reset;
    logic              frame_clk;
    logic              newNote;
    logic              hit;
    logic [3:0]        speed;
    logic [9:0]        tile_x;
    logic [9:0]        tile_s;
    logic [10*SLOTS-1:0] tile_y;
    logic [SLOTS-1:0]  tile_v;
    logic              hit_ok;
    logic              miss;
    logic              spawn_drop;

    int n_pass  = 0;
    int n_total = 0;

    int m_v [SLOTS];
    int m_y [SLOTS];
    int m_s [SLOTS];
    bit e_hit, e_miss, e_drop;

    tile_lane_ctrl dut (
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .newNote    (newNote),
        .hit        (hit),
        .speed      (speed),
        .tile_x     (tile_x),
        .tile_s     (tile_s),
        .tile_y     (tile_y),
        .tile_v     (tile_v),
        .hit_ok     (hit_ok),
        .miss       (miss),
        .spawn_drop (spawn_drop)
    );

    initial frame_clk = 1'b0;
    always #5 frame_clk = ~frame_clk;

    task automatic model_reset();
        for (int i = 0; i < SLOTS; i++) begin
            m_v[i] = 0; m_y[i] = 0; m_s[i] = 0;
        end
        e_hit = 0; e_miss = 0; e_drop = 0;
    endtask

    // One frame of lane rules, applied to a snapshot of the pre-edge lane.
    task automatic model_step(input bit nn, input bit h, input int spd);
        int tgt = -1;
        int free = -1;
        bit kill [SLOTS];
        e_hit = 0; e_miss = 0; e_drop = 0;
        for (int i = 0; i < SLOTS; i++) begin
            kill[i] = 0;
            if (m_v[i] != 0 && (tgt < 0 || m_y[i] > m_y[tgt])) tgt = i;
            if (m_v[i] == 0 && free < 0) free = i;
        end
`ifdef TILE_LANE_AUTOPLAY_EN
        for (int i = 0; i < SLOTS; i++)
            if (m_v[i] != 0 && m_y[i] + TILE_H >= HIT_TOP) begin kill[i] = 1; e_hit = 1; end
`else
        if (h) begin
            if (tgt >= 0 && m_y[tgt] + TILE_H >= HIT_TOP) begin kill[tgt] = 1; e_hit = 1; end
            else e_miss = 1;
        end
`endif
        for (int i = 0; i < SLOTS; i++)
            if (m_v[i] != 0 && !kill[i] && m_y[i] + TILE_H >= SCR_H - 1) begin kill[i] = 1; e_miss = 1; end
        for (int i = 0; i < SLOTS; i++) begin
            if (m_v[i] != 0) begin
                if (kill[i]) begin m_v[i] = 0; m_y[i] = 0; end
                else m_y[i] = m_y[i] + m_s[i];
            end
        end
        if (nn) begin
            if (free >= 0) begin m_v[free] = 1; m_y[free] = 0; m_s[free] = BASE + spd; end
            else e_drop = 1;
        end
    endtask

    task automatic cycle(input bit nn, input bit h, input int spd);
        @(negedge frame_clk);
        newNote = nn; hit = h; speed = 4'(spd);
        @(posedge frame_clk);
        model_step(nn, h, spd);
        #1;
    endtask

    task automatic do_reset();
        @(negedge frame_clk);
        Reset = 1'b1; newNote = 1'b0; hit = 1'b0; speed = 4'd0;
        #3;
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        Reset = 1'b1; newNote = 1'b0; hit = 1'b0; speed = 4'd0;
        #12;
        n_total++; if (tile_v !== 4'b0000) $display("FAIL reset_v got %b want 0000", tile_v); else n_pass++;
        n_total++; if (tile_y !== 40'd0) $display("FAIL reset_y got %h want 0", tile_y); else n_pass++;
        n_total++; if ({hit_ok, miss, spawn_drop} !== 3'b000) $display("FAIL reset_pulses got %b want 000", {hit_ok, miss, spawn_drop}); else n_pass++;
        n_total++; if (tile_x !== 10'd400 || tile_s !== 10'd75) $display("FAIL consts got x=%0d s=%0d want 400 75", tile_x, tile_s); else n_pass++;
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();
    endtask

    task automatic test_hit_window();
        do_reset();
        cycle(1, 0, 0);
        n_total++; if (tile_v !== 4'b0001 || tile_y[9:0] !== 10'd0) $display("FAIL spawn0 got v=%b y=%0d want 0001 0", tile_v, tile_y[9:0]); else n_pass++;
        cycle(0, 0, 0);
        n_total++; if (tile_y[9:0] !== 10'd3) $display("FAIL step3 got %0d want 3", tile_y[9:0]); else n_pass++;
        repeat (93) cycle(0, 0, 0);
        n_total++; if (tile_y[9:0] !== 10'd282) $display("FAIL frame94 got %0d want 282", tile_y[9:0]); else n_pass++;
        cycle(0, 0, 0);
        cycle(0, 1, 0);
        n_total++; if (hit_ok !== 1'b1 || miss !== 1'b0 || tile_v !== 4'b0000) $display("FAIL good_hit got ok=%b miss=%b v=%b want 1 0 0000", hit_ok, miss, tile_v); else n_pass++;
        cycle(0, 0, 0);
        n_total++; if (hit_ok !== 1'b0) $display("FAIL hit_pulse_len got %b want 0", hit_ok); else n_pass++;
    endtask

    task automatic test_early_miss();
        do_reset();
        cycle(1, 0, 0);
        repeat (94) cycle(0, 0, 0);
        cycle(0, 1, 0);
        n_total++; if (miss !== 1'b1 || hit_ok !== 1'b0) $display("FAIL early_hit got miss=%b ok=%b want 1 0", miss, hit_ok); else n_pass++;
        n_total++; if (tile_v !== 4'b0001 || tile_y[9:0] !== 10'd285) $display("FAIL early_keep got v=%b y=%0d want 0001 285", tile_v, tile_y[9:0]); else n_pass++;
        do_reset();
        cycle(0, 1, 0);
        n_total++; if (miss !== 1'b1) $display("FAIL empty_hit got %b want 1", miss); else n_pass++;
    endtask

    task automatic test_fall_off();
        do_reset();
        cycle(1, 0, 0);
        repeat (135) cycle(0, 0, 0);
        n_total++; if (tile_y[9:0] !== 10'd405 || miss !== 1'b0) $display("FAIL pre_fall got y=%0d miss=%b want 405 0", tile_y[9:0], miss); else n_pass++;
        cycle(0, 0, 0);
        n_total++; if (tile_v !== 4'b0000 || miss !== 1'b1 || tile_y[9:0] !== 10'd0) $display("FAIL fall_off got v=%b miss=%b y=%0d want 0000 1 0", tile_v, miss, tile_y[9:0]); else n_pass++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        repeat (4) cycle(1, 0, 0);
        n_total++; if (tile_v !== 4'b1111 || tile_y !== {10'd0, 10'd3, 10'd6, 10'd9}) $display("FAIL fill got v=%b y=%h want 1111", tile_v, tile_y); else n_pass++;
        cycle(1, 0, 0);
        n_total++; if (spawn_drop !== 1'b1 || tile_v !== 4'b1111) $display("FAIL drop got d=%b v=%b want 1 1111", spawn_drop, tile_v); else n_pass++;
        repeat (92) cycle(0, 0, 0);
        n_total++; if (tile_y[19:10] !== 10'd285 || tile_y[9:0] !== 10'd288) $display("FAIL window got y1=%0d y0=%0d want 285 288", tile_y[19:10], tile_y[9:0]); else n_pass++;
        cycle(0, 1, 0);
        n_total++; if (tile_v !== 4'b1110 || hit_ok !== 1'b1) $display("FAIL target got v=%b ok=%b want 1110 1", tile_v, hit_ok); else n_pass++;
        cycle(1, 0, 0);
        n_total++; if (tile_v !== 4'b1111 || tile_y[9:0] !== 10'd0) $display("FAIL reuse got v=%b y0=%0d want 1111 0", tile_v, tile_y[9:0]); else n_pass++;
    endtask

    task automatic test_speed_latch();
        do_reset();
        cycle(1, 0, 5);
        cycle(1, 0, 15);
        n_total++; if (tile_y[9:0] !== 10'd8 || tile_y[19:10] !== 10'd0) $display("FAIL speed1 got y0=%0d y1=%0d want 8 0", tile_y[9:0], tile_y[19:10]); else n_pass++;
        cycle(0, 0, 15);
        n_total++; if (tile_y[9:0] !== 10'd16 || tile_y[19:10] !== 10'd18) $display("FAIL speed2 got y0=%0d y1=%0d want 16 18", tile_y[9:0], tile_y[19:10]); else n_pass++;
    endtask

    task automatic test_reset_midfall();
        do_reset();
        repeat (3) cycle(1, 0, 0);
        repeat (10) cycle(0, 0, 0);
        cycle(0, 1, 0);
        n_total++; if (miss !== 1'b1 || tile_v !== 4'b0111) $display("FAIL pre_reset got miss=%b v=%b want 1 0111", miss, tile_v); else n_pass++;
        #2;
        Reset = 1'b1;
        #1;
        n_total++; if (tile_v !== 4'b0000 || tile_y !== 40'd0 || {hit_ok, miss, spawn_drop} !== 3'b000) $display("FAIL async_reset got v=%b y=%h p=%b want 0", tile_v, tile_y, {hit_ok, miss, spawn_drop}); else n_pass++;
        @(negedge frame_clk);
        Reset = 1'b0;
        model_reset();
        cycle(1, 0, 0);
        n_total++; if (tile_v !== 4'b0001 || tile_y[9:0] !== 10'd0) $display("FAIL post_reset got v=%b y0=%0d want 0001 0", tile_v, tile_y[9:0]); else n_pass++;
    endtask

    task automatic test_random();
        logic [SLOTS-1:0] exp_v;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            cycle(($urandom % 7) == 0, ($urandom % 12) == 0, int'($urandom % 16));
            exp_v = '0;
            for (int i = 0; i < SLOTS; i++) exp_v[i] = (m_v[i] != 0);
            n_total++; if (tile_v !== exp_v) $display("FAIL rnd_v c=%0d got %b want %b", c, tile_v, exp_v); else n_pass++;
            for (int i = 0; i < SLOTS; i++) begin
                n_total++;
                if (tile_y[10*i +: 10] !== 10'(m_y[i])) $display("FAIL rnd_y%0d c=%0d got %0d want %0d", i, c, tile_y[10*i +: 10], m_y[i]);
                else n_pass++;
            end
            n_total++;
            if ({hit_ok, miss, spawn_drop} !== {e_hit, e_miss, e_drop})
                $display("FAIL rnd_pulses c=%0d got %b want %b", c, {hit_ok, miss, spawn_drop}, {e_hit, e_miss, e_drop});
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_hit_window();
        test_early_miss();
        test_fall_off();
        test_back_to_back();
        test_speed_latch();
        test_reset_midfall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/tile_lane_ctrl.md
Name: tile_lane_ctrl

Overview:
Multi-tile controller for one piano lane. It holds up to SLOTS falling tiles and spawns a tile on each newNote pulse. Every frame it moves each active tile down by that tile's own latched step, then resolves key hits against a hit window and retires tiles that reach the bottom as misses. One instance per lane feeds the sprite renderer (tile positions) and the score logic (hit/miss pulses).

Parameters:
SLOTS, 4, max simultaneous tiles in the lane (1..8)
LANE_X, 400, fixed X coordinate of all tiles in the lane
TILE_H, 75, tile height/size in pixels
SCREEN_H, 480, visible rows; bottom row is SCREEN_H-1
HIT_TOP, 360, a tile is hittable when y+TILE_H >= HIT_TOP
BASE_STEP, 3, step added to speed at spawn

Ports:
Reset  in  1  asynchronous, active-high
frame_clk  in  1  one edge per video frame
newNote  in  1  spawn request, one frame
hit  in  1  lane key pressed this frame, one frame
speed  in  4  speed setting, sampled at spawn only
tile_x  out  10  LANE_X
tile_s  out  10  TILE_H
tile_y  out  10*SLOTS  packed Y of slot i at [10i+9:10i]
tile_v  out  SLOTS  slot i active
hit_ok  out  1  one-frame pulse: good hit
miss  out  1  one-frame pulse: wrong press or tile fell off
spawn_drop  out  1  one-frame pulse: newNote with no free slot

Behaviour:
- Clocking: all state and outputs are registered on posedge frame_clk. Reset is asynchronous.
- Reset values: tile_v=0, all tile_y=0, hit_ok=0, miss=0, spawn_drop=0.
- Per-slot state: valid, y[9:0], step[9:0]. step = BASE_STEP + speed, zero-extended, latched at spawn and never changed afterwards. Each move uses the latched step.
- Evaluation per edge uses pre-edge state only. Order of resolution:
  1. Target = valid slot with largest y; ties go to the lowest index.
  2. If hit=1 and no target exists, or target y+TILE_H < HIT_TOP: miss=1, no tile changes.
  3. If hit=1 and target y+TILE_H >= HIT_TOP: target valid<=0, hit_ok=1.
  4. Every other valid slot with y+TILE_H >= SCREEN_H-1: valid<=0, miss=1 (multiple fall-offs give one pulse).
  5. Remaining valid slots: y <= y+step.
  6. If newNote=1: the lowest-index slot that was invalid pre-edge gets valid<=1, y<=0, step latched. If no slot was free: spawn_drop=1.
- A slot freed on an edge is not reusable until the next edge.
- Hit wins over fall-off when both apply to the target on the same edge.
- hit_ok and miss may both be 1 on the same edge (hit on the target, fall-off on another slot).
- Width: y+step and y+TILE_H are computed 11 bits wide, so there is no wrap. A tile is always retired before y+step can exceed 10 bits.
- Invalid slots report tile_y = 0.
- Reset mid-fall clears all slots immediately. Pulses are never longer than one frame.

Optional Feature:
TILE_LANE_AUTOPLAY_EN
- Defined: the hit input is ignored. Any valid slot with y+TILE_H >= HIT_TOP is retired with hit_ok=1 on that edge (demo/attract mode). miss never asserts for wrong presses. Fall-off cannot occur, because HIT_TOP < SCREEN_H-1.
- Undefined: behaviour as in Behaviour.

Decomposition:
- Package tile_pkg: COORD_W=10, SCREEN_W=640, SCREEN_H=480; typedef coord_t (logic [9:0]); struct tile_slot_t {valid, coord_t y, coord_t step}.
- Sub-module tile_slot: one slot's registers plus move/spawn/clear. It takes spawn, clear and step_in inputs and produces valid, y and at_bottom outputs. The parent instantiates SLOTS copies with a generate loop and owns target selection, free-slot priority encoding and the pulses.

Test Plan:
- Spawn with speed=0 (step 3): tile_y0 = 3k after k frames. At frame 95 y=285, which is hittable; hit there -> hit_ok=1, tile_v0=0 next frame.
- Spawn, hit at frame 94 (y=282) -> miss=1 and the tile keeps moving (y=285 next frame). Hit with no tile active -> miss=1.
- Spawn and never hit: at y=405 (405+75 >= 479) the next edge clears the slot with miss=1.
- SLOTS=4: five newNote pulses on consecutive frames -> slots 0..3 valid, fifth gives spawn_drop=1. Hit after both slot 0 and slot 1 are in the window -> slot 0 (largest y) retired.
- Spawn with speed=5 (step 8), then change speed to 15 -> that tile keeps step 8; a new spawn gets step 18.
- Reset pulsed while 3 tiles are falling -> tile_v=0 and all pulses 0 immediately; newNote after reset uses slot 0. With TILE_LANE_AUTOPLAY_EN: no hit input, tile retired with hit_ok at y=285 (step 3).
